// File: rtl/blink_rate_decoder_if.sv
// Bus between the blinking-light source side and the rate decoder.
// The master drives tick and light_in and observes the measurement results.
interface blink_rate_decoder_if #(
    parameter int unsigned CNT_W = 4
);
    logic             tick;
    logic             light_in;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic [3:0]       rate_code;
    logic             locked;
    logic             stalled;

    modport master (
        output tick,
        output light_in,
        input  half_period,
        input  period_valid,
        input  rate_code,
        input  locked,
        input  stalled
    );

    modport slave (
        input  tick,
        input  light_in,
        output half_period,
        output period_valid,
        output rate_code,
        output locked,
        output stalled
    );
endinterface

// File: rtl/blink_rate_decoder.sv
// Recovers the programmed blink rate from a light waveform: measures ticks between
// light edges, decodes the half-period to a one-hot rate, and flags lock and stall.
module blink_rate_decoder #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_TICKS = 15
) (
    input logic                 clk,
    input logic                 rst,
    blink_rate_decoder_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_TICKS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             light_d_q;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic             valid_q, valid_d;
    logic [3:0]       rate_q, rate_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;
    // A capture has happened since the last arm from idle; gates lock detection.
    logic             have_cap_q, have_cap_d;

    logic             light_edge;
    logic [CNT_W-1:0] close_val;

    function automatic logic [3:0] decode(input logic [CNT_W-1:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v == CNT_W'(1)) r = 4'b0001;
        if (v == CNT_W'(2)) r = 4'b0010;
        if (v == CNT_W'(4)) r = 4'b0100;
        if (v == CNT_W'(8)) r = 4'b1000;
        return r;
    endfunction

    assign light_edge = bus.light_in ^ light_d_q;
    // A tick landing on the closing edge still belongs to the interval being closed.
    assign close_val  = cnt_q + {{(CNT_W-1){1'b0}}, bus.tick};

    // Next-state logic: measurement FSM, capture and flag updates.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        half_period_d = half_period_q;
        valid_d       = 1'b0;
        rate_d        = rate_q;
        locked_d      = locked_q;
        stalled_d     = stalled_q;
        have_cap_d    = have_cap_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (light_edge) begin
                    state_d    = StCount;
                    stalled_d  = 1'b0;
                    have_cap_d = 1'b0;
                end
            end
            StCount: begin
                if (light_edge) begin
                    cnt_d = '0;
                    // Zero-tick intervals are glitches: restart counting only.
                    if (close_val != '0) begin
                        half_period_d = close_val;
                        rate_d        = decode(close_val);
                        valid_d       = 1'b1;
                        locked_d      = have_cap_q && (close_val == half_period_q);
                        have_cap_d    = 1'b1;
                    end
                end else if (bus.tick) begin
                    if (cnt_q == LastCnt) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        stalled_d = 1'b1;
                        locked_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            light_d_q     <= 1'b0;
            half_period_q <= '0;
            valid_q       <= 1'b0;
            rate_q        <= 4'b0000;
            locked_q      <= 1'b0;
            stalled_q     <= 1'b0;
            have_cap_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            light_d_q     <= bus.light_in;
            half_period_q <= half_period_d;
            valid_q       <= valid_d;
            rate_q        <= rate_d;
            locked_q      <= locked_d;
            stalled_q     <= stalled_d;
            have_cap_q    <= have_cap_d;
        end
    end

    assign bus.half_period  = half_period_q;
    assign bus.period_valid = valid_q;
    assign bus.rate_code    = rate_q;
    assign bus.locked       = locked_q;
    assign bus.stalled      = stalled_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder: stimulus pushes expected captures into a
// queue, a monitor pops and compares on every period_valid pulse.
module tb_blink_rate_decoder;

    typedef struct packed {
        logic [3:0] hp;
        logic [3:0] rc;
        logic       lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    blink_rate_decoder_if #(.CNT_W(4)) bus ();

    blink_rate_decoder #(
        .CNT_W    (4),
        .MAX_TICKS(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick cycle followed by three quiet cycles.
    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic toggle();
        bus.light_in = ~bus.light_in;
        step();
    endtask

    // n ticks then an edge in a tick-free cycle, closing an interval of n.
    task automatic interval(input int n, input logic [3:0] rc, input logic lk);
        for (int i = 0; i < n; i++) do_tick();
        exp_q.push_back('{hp: 4'(n), rc: rc, lk: lk});
        toggle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_half_period"}, int'(bus.half_period), 0);
        check({tag, "_valid"}, int'(bus.period_valid), 0);
        check({tag, "_rate_code"}, int'(bus.rate_code), 0);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_stalled"}, int'(bus.stalled), 0);
    endtask

    // Scoreboard monitor: compare each valid pulse with the oldest expected capture.
    always @(negedge clk) begin
        if (!rst && bus.period_valid) begin
            check("valid_not_back_to_back", int'(prev_valid), 0);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got half_period %0d, required no pulse",
                         bus.half_period);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cap_half_period", int'(bus.half_period), int'(e.hp));
                check("cap_rate_code", int'(bus.rate_code), int'(e.rc));
                check("cap_locked", int'(bus.locked), int'(e.lk));
            end
        end
        prev_valid = bus.period_valid;
    end

    initial begin
        bus.tick     = 1'b0;
        bus.light_in = 1'b0;

        // 1: reset held with light toggling
        rst = 1'b1;
        step();
        bus.light_in = 1'b1;
        step();
        bus.light_in = 1'b0;
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // 2: steady 4-tick half-period
        toggle();                       // arms only
        interval(4, 4'b0100, 1'b0);
        interval(4, 4'b0100, 1'b1);
        interval(4, 4'b0100, 1'b1);

        // 3: rate change to 2 ticks
        interval(2, 4'b0010, 1'b0);
        interval(2, 4'b0010, 1'b1);

        // 4: stop toggling -> stall after 15 ticks
        for (int i = 0; i < 14; i++) do_tick();
        check("pre_timeout_stalled", int'(bus.stalled), 0);
        check("pre_timeout_locked", int'(bus.locked), 1);
        do_tick();
        check("stalled", int'(bus.stalled), 1);
        check("stall_locked", int'(bus.locked), 0);
        check("stall_hp_held", int'(bus.half_period), 2);
        check("stall_rc_held", int'(bus.rate_code), 4'b0010);
        toggle();                       // clears stall, arms, no capture
        step();
        check("stall_cleared", int'(bus.stalled), 0);
        interval(3, 4'b0000, 1'b0);

        // 5: tick coincident with the closing edge counts toward the interval
        do_tick();
        do_tick();
        exp_q.push_back('{hp: 4'd3, rc: 4'b0000, lk: 1'b1});
        bus.tick     = 1'b1;
        bus.light_in = ~bus.light_in;
        step();
        bus.tick = 1'b0;
        step();
        // two edges between ticks: the second is a glitch
        do_tick();
        do_tick();
        exp_q.push_back('{hp: 4'd2, rc: 4'b0010, lk: 1'b0});
        toggle();
        toggle();
        step();
        check("glitch_hp_held", int'(bus.half_period), 2);
        interval(2, 4'b0010, 1'b1);

        // 6: reset mid-count with cnt=7
        for (int i = 0; i < 7; i++) do_tick();
        rst          = 1'b1;
        bus.light_in = 1'b0;
        step();
        check_all_zero("mid_reset");
        rst = 1'b0;
        step();
        toggle();                       // arms only
        step();
        check("post_reset_no_capture", int'(bus.half_period), 0);
        interval(1, 4'b0001, 1'b0);

        step();
        step();
        check("expected_captures_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
